// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer: captures UART bytes with their parity/frame flags
// and presents them through valid/ready, reporting occupancy and lost bytes.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     drop_err_en,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_parity_error,
    input  logic                     in_frame_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_parity_error,
    output logic                     out_frame_error,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LVL);

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, level_reg;
    logic [PW-1:0] wr_ptr_next, rd_ptr_next, level_next;
    logic          empty_reg, full_reg, almost_full_reg, overflow_reg;
    logic [7:0]    drop_cnt_reg;
    logic [9:0]    head;
    logic          push_req, pop, push_acc, ovf_evt;

    // Errored bytes are filtered before they ever count as a push request.
    assign push_req = in_valid && !(drop_err_en && (in_parity_error || in_frame_error));
    assign pop      = !empty_reg && out_ready;
    assign push_acc = push_req && (!full_reg || pop);
    assign ovf_evt  = push_req && full_reg && !pop;

    assign head = mem[rd_ptr_reg[AW-1:0]];
    assign {out_frame_error, out_parity_error, out_data} = empty_reg ? 10'd0 : head;

    assign out_valid   = !empty_reg;
    assign level       = level_reg;
    assign empty       = empty_reg;
    assign full        = full_reg;
    assign almost_full = almost_full_reg;
    assign overflow    = overflow_reg;
    assign drop_cnt    = drop_cnt_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_acc};
        rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop};
        level_next  = level_reg + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (push_acc && !clr)
            mem[wr_ptr_reg[AW-1:0]] <= {in_frame_error, in_parity_error, in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            empty_reg       <= 1'b1;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            drop_cnt_reg    <= 8'd0;
        end else if (clr) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            level_reg       <= '0;
            empty_reg       <= 1'b1;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            drop_cnt_reg    <= 8'd0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            level_reg       <= level_next;
            empty_reg       <= (wr_ptr_next == rd_ptr_next);
            full_reg        <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                               (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
            almost_full_reg <= (level_next >= AFULL_THR);
            // A new loss in the clearing cycle restarts the count at one.
            if (ovf_evt) begin
                overflow_reg <= 1'b1;
                drop_cnt_reg <= overflow_clr ? 8'd1 :
                                (drop_cnt_reg == 8'hFF) ? 8'hFF : drop_cnt_reg + 8'd1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo against a queue-level model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic       clk = 1'b0;
    logic       rst, clr, drop_err_en, in_valid, in_parity_error, in_frame_error;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_parity_error, out_frame_error;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       empty, full, almost_full, overflow, overflow_clr;
    logic [7:0] drop_cnt;

    uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk(clk), .rst(rst), .clr(clr), .drop_err_en(drop_err_en),
        .in_valid(in_valid), .in_data(in_data),
        .in_parity_error(in_parity_error), .in_frame_error(in_frame_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity_error(out_parity_error), .out_frame_error(out_frame_error),
        .level(level), .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .overflow_clr(overflow_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] sb[$];
    int         m_level = 0;
    logic       m_ovf = 1'b0;
    int         m_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL pop_unexpected: got 0x%0h expected no entry", out_data);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                $display("[TB] pop data=0x%02h pe=%0b fe=%0b", out_data, out_parity_error, out_frame_error);
                chk("pop_entry", {22'd0, out_frame_error, out_parity_error, out_data}, {22'd0, e});
            end
        end
    end

    task automatic check_status();
        chk("level", {27'd0, level}, m_level);
        chk("empty", {31'd0, empty}, {31'd0, m_level == 0});
        chk("full", {31'd0, full}, {31'd0, m_level == DEPTH});
        chk("almost_full", {31'd0, almost_full}, {31'd0, m_level >= AFULL});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_level > 0});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
        if (m_level > 0)
            chk("head", {22'd0, out_frame_error, out_parity_error, out_data}, {22'd0, sb[0]});
        else
            chk("idle_out", {22'd0, out_frame_error, out_parity_error, out_data}, 32'd0);
    endtask

    // One clock of stimulus; the model decides the outcome from occupancy alone.
    task automatic step(input logic v, input logic [7:0] d, input logic pe, input logic fe,
                        input logic rdy, input logic dee, input logic oc, input logic c);
        logic preq, pop_m, acc, evt;
        in_valid = v; in_data = d; in_parity_error = pe; in_frame_error = fe;
        out_ready = rdy; drop_err_en = dee; overflow_clr = oc; clr = c;
        preq  = v && !(dee && (pe || fe));
        pop_m = (m_level > 0) && rdy;
        if (c) begin
            m_level = 0; sb.delete(); m_ovf = 1'b0; m_drop = 0;
        end else begin
            acc = preq && (m_level < DEPTH || pop_m);
            evt = preq && !acc;
            if (acc) sb.push_back({fe, pe, d});
            m_level = m_level + int'(acc) - int'(pop_m);
            if (evt) begin
                m_ovf  = 1'b1;
                m_drop = oc ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
            end else if (oc) begin
                m_ovf = 1'b0; m_drop = 0;
            end
        end
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0; overflow_clr = 0; clr = 0;
        in_parity_error = 0; in_frame_error = 0;
        check_status();
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) pop1();
    endtask

    initial begin
        int n;
        rst = 1; clr = 0; drop_err_en = 0; in_valid = 0; in_data = 0;
        in_parity_error = 0; in_frame_error = 0; out_ready = 0; overflow_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check_status();

        // Single byte, then pop it.
        push(8'hA5);
        pop1();

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'h10);
        drain();

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'(i));
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Error tagging and filtering.
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h3E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Wrap-around at a random standing level.
        n = $urandom_range(15, 1);
        for (int i = 0; i < n; i++) push(8'($urandom));
        for (int i = 0; i < 40; i++)
            step(1'b1, 8'($urandom), 1'($urandom % 5 == 0), 1'($urandom % 7 == 0),
                 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Clear at level 5 with overflow set, then set-beats-clear priority.
        for (int i = 0; i < 16; i++) push(8'(i));
        push(8'h77);
        for (int i = 0; i < 11; i++) pop1();
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        step(1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // drop_cnt saturation, then overflow_clr alone.
        for (int i = 0; i < 258; i++) push(8'($urandom));
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Random traffic with occasional clears and stalls.
        for (int i = 0; i < 600; i++)
            step(1'($urandom % 4 != 0), 8'($urandom), 1'($urandom % 8 == 0),
                 1'($urandom % 8 == 0), 1'($urandom % 3 == 0), 1'($urandom % 2),
                 1'($urandom % 20 == 0), 1'($urandom % 80 == 0));

        // Reset mid-stream empties immediately.
        for (int i = 0; i < 6; i++) push(8'(i));
        rst = 1;
        #1;
        chk("async_rst_level", {27'd0, level}, 32'd0);
        chk("async_rst_empty", {31'd0, empty}, 32'd1);
        m_level = 0; sb.delete(); m_ovf = 1'b0; m_drop = 0;
        @(posedge clk); #1;
        rst = 0;
        check_status();
        pop1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer between the UART receiver and its consumer, either the loopback transmitter or a host interface. It captures each received byte on the receiver's single-cycle valid strobe, together with that byte's parity and frame error flags. Entries are presented downstream through a first-word-fall-through valid/ready interface. It decouples the receiver's fixed-rate output from a consumer that may stall, and reports occupancy and overflow.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2
AFULL_LVL, 12, level at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush of contents and status
drop_err_en  input  1  1 = discard incoming bytes with parity or frame error
in_valid  input  1  single-cycle strobe from receiver: byte available
in_data  input  8  received byte
in_parity_error  input  1  parity error flag qualified by in_valid
in_frame_error  input  1  frame error flag qualified by in_valid
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  8  head entry byte
out_parity_error  output  1  head entry parity error flag
out_frame_error  output  1  head entry frame error flag
level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH
empty  output  1  level == 0
full  output  1  level == DEPTH
almost_full  output  1  level >= AFULL_LVL
overflow  output  1  sticky: a byte was lost because the FIFO was full
overflow_clr  input  1  clears overflow
drop_cnt  output  8  saturating count of bytes lost to overflow

Behaviour:
- Reset (rst=1, asynchronous): pointers=0, level=0, out_valid=0, empty=1, full=0, almost_full=0, overflow=0, drop_cnt=0. out_data and out_*_error read 0 while empty.
- Storage: DEPTH x 10-bit entries {frame_err, parity_err, data}. Read and write pointers are $clog2(DEPTH)+1 bits wide. The extra MSB is the wrap bit. Full = pointer MSBs differ and the low bits are equal.
- Push request: in_valid=1, and not (drop_err_en=1 and (in_parity_error or in_frame_error)). A filtered byte is ignored entirely; it does not count as a drop and does not set overflow.
- Pop: out_valid and out_ready both high on a rising edge.
- FWFT: out_valid = !empty. out_* are driven combinationally from the entry at the read pointer. A byte pushed into an empty FIFO at edge k is visible with out_valid=1 from edge k, i.e. one cycle after the strobe. There is no empty-FIFO bypass in the same cycle.
- out_ready while out_valid=0: ignored.
- Push while not full: write at the write pointer, then increment it.
- Push while full with a simultaneous pop: both are accepted, level stays DEPTH, and no overflow.
- Push while full without a pop: the byte is discarded, overflow is set, and drop_cnt increments, saturating at 255.
- Push and pop in the same cycle otherwise: level is unchanged and both pointers advance.
- Pointer wrap: low bits roll from DEPTH-1 to 0 and the wrap bit toggles.
- level, empty, full and almost_full are registered and consistent with the pointers after every edge.
- overflow_clr: clears overflow and drop_cnt on the next edge. If an overflow event occurs in the same cycle, the set wins: overflow=1 and drop_cnt=1.
- clr: on the next edge, clears pointers, level, overflow and drop_cnt. Any push or pop in that cycle is ignored. Output state then matches reset.
- out_data is stable while out_valid=1 and out_ready=0. The consumer may stall indefinitely.
- Reset mid-stream: the FIFO empties immediately, and stored data is not recoverable.

Test Plan:
- Single byte: after reset, pulse in_valid with data=0xA5 and flags 0, out_ready=0. Required: out_valid=1 and out_data=0xA5 one cycle later, level=1. Then raise out_ready for one cycle. Required: empty=1, level=0.
- Fill and overflow (DEPTH=16): push 0x00..0x0F with no pops. Required: full=1, and almost_full=1 from the 12th push. Push 0x10. Required: overflow=1, drop_cnt=1. Pop all. Required: data 0x00..0x0F in order; 0x10 never appears.
- Full with simultaneous push and pop: FIFO full; push 0x55 with out_ready=1 in the same cycle. Required: head 0x00 popped, level stays 16, overflow=0, 0x55 emerges last.
- Error tagging and filtering: with drop_err_en=0, push 0x3C with parity error. Required: out_parity_error=1 at the head. With drop_err_en=1, push 0x3D with frame error. Required: level unchanged, overflow=0.
- Wrap-around: 40 push/pop pairs at a random level between 1 and 15. Required: output sequence matches a reference queue exactly, and level never exceeds 16.
- Clear and set-priority: at level 5 with overflow=1, assert clr. Required: level=0, empty=1, overflow=0. Fill to 16, then in one cycle push with overflow_clr=1. Required: overflow=1, drop_cnt=1.
